mmu_systolic_array: RTL and testbench
=====================================

Name: mmu_systolic_array

Overview:
- 2x2 output-stationary systolic matrix-multiply unit. It sits directly downstream of the TPU control unit and consumes its mmu_en / mmu_cycle sequencing plus the flattened A (weights) and B (inputs) matrices from operand memory.
- Computes C = A x B using internally skewed operand injection.
- Captures the four results into holding registers and serves one element at a time, selected by output_select.

Parameters:
- DATA_W, 8, operand element width (unsigned)
- ACC_W, 16, accumulator and result width (unsigned, modulo 2^ACC_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- mmu_en  in  1  compute enable from control unit
- mmu_cycle  in  3  compute step index from control unit (0..5)
- weights  in  4*DATA_W  matrix A; [DATA_W-1:0]=A00, then A01, A10, A11
- inputs  in  4*DATA_W  matrix B; same packing, B00, B01, B10, B11
- output_select  in  2  result element select: 0=C00, 1=C01, 2=C10, 3=C11
- result  out  ACC_W  registered selected result element
- result_valid  out  1  high when the holding registers contain a completed product
- done  out  1  one-cycle pulse when results are captured

Behaviour:
- Reset (rst_n=0 at a clock edge): all PE accumulators, forwarding registers, holding registers, result, result_valid and done go to 0. Reset mid-compute aborts the operation, with no partial capture.
- PE grid: PE(i,j) holds acc_ij.
  - Each PE forwards a rightward and b downward through one register each.
  - PE(0,j) takes b from the top edge; PE(i,0) takes a from the left edge.
- Edge injection is combinational from mmu_cycle t when mmu_en=1, otherwise 0:
  - row0 a = A00 at t=0, A01 at t=1
  - row1 a = A10 at t=1, A11 at t=2
  - col0 b = B00 at t=0, B10 at t=1
  - col1 b = B01 at t=1, B11 at t=2
  - Every other case drives 0.
- Per-PE update when mmu_en=1:
  - t==0: acc <= a*b (overwrite, clears the previous result).
  - t in 1..3: acc <= acc + a*b.
  - t>=4: acc holds.
  - Products and sums are truncated to ACC_W; wrap-around is not flagged.
- Forwarding registers load every edge while mmu_en=1 and clear to 0 while mmu_en=0.
- mmu_cycle==0 held for multiple cycles is idempotent; the control unit does hold it for 2 cycles.
- The last contribution lands in PE(1,1) at t=3.
- Capture FSM states: IDLE, RUN, HOLD.
  - IDLE -> RUN on mmu_en=1 && t==0; result_valid <= 0 on this transition.
  - RUN -> HOLD on mmu_en=1 && t==4: copy all acc into the holding registers, result_valid <= 1, done=1 for exactly that one cycle.
  - RUN -> IDLE if mmu_en drops before t==4 (abort): holding registers and result_valid are unchanged from before the abort (they stay 0 because RUN entry cleared valid).
  - HOLD -> RUN on mmu_en=1 && t==0 (new operation); HOLD -> IDLE is never taken; results persist.
  - t==5 in HOLD: no effect.
- Operands weights/inputs must be stable from t=0 through t=2. They are not latched.
- result <= holding[output_select] every edge: 1-cycle latency from an output_select change or a capture. Selection is independent of mmu_en.
- Simultaneous new start (t==0) while in HOLD: result_valid drops the next cycle. The holding registers keep the old values until the next capture.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], drive mmu_en=1 with t=0,0,1,2,3,4,5 -> done pulses once at the t=4 edge; output_select 0..3 gives 19, 22, 43, 50 one cycle later; result_valid=1.
- A and B all 255 -> every C element = 130050 mod 65536 = 64514 (0xFC02); no other flag.
- Second operation with A=identity, B=[[9,8],[7,6]] after the first -> result_valid drops after t=0; next capture gives 9, 8, 7, 6. No residue from the prior accumulation.
- mmu_en dropped at t=2 -> no done pulse, result_valid stays 0, result=0.
- rst_n=0 asserted at t=3 -> all outputs 0 after that edge. A following full sequence after release produces correct results.
- After a capture, hold mmu_en=0 and sweep output_select 3,2,1,0 -> result tracks with exactly 1-cycle latency; values stable.

Source files
------------

// File: rtl/mmu_systolic_array_if.sv
// rtl/mmu_systolic_array_if.sv - control, operand and result signals of the 2x2 systolic MMU
interface mmu_systolic_array_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
);
    logic                  mmu_en;
    logic [2:0]            mmu_cycle;
    logic [4*DATA_W-1:0]   weights;
    logic [4*DATA_W-1:0]   inputs;
    logic [1:0]            output_select;
    logic [ACC_W-1:0]      result;
    logic                  result_valid;
    logic                  done;

    modport master (
        output mmu_en, mmu_cycle, weights, inputs, output_select,
        input  result, result_valid, done
    );

    modport slave (
        input  mmu_en, mmu_cycle, weights, inputs, output_select,
        output result, result_valid, done
    );
endinterface

// File: rtl/mmu_systolic_array.sv
// rtl/mmu_systolic_array.sv - 2x2 output-stationary systolic matrix multiply with result holding registers
module mmu_systolic_array #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mmu_systolic_array_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   capture, start;

    logic [DATA_W-1:0] w_el [4];
    logic [DATA_W-1:0] i_el [4];
    logic [DATA_W-1:0] a_row0, a_row1, b_col0, b_col1;

    // Forwarding registers: a moves right out of column 0, b moves down out of row 0
    logic [DATA_W-1:0] a_fwd00, a_fwd10, b_fwd00, b_fwd01;

    // PE index k = i*2 + j
    logic [DATA_W-1:0]   pe_a [4];
    logic [DATA_W-1:0]   pe_b [4];
    logic [2*DATA_W-1:0] prod [4];
    logic [ACC_W-1:0]    acc  [4];
    logic [ACC_W-1:0]    holding [4];
    logic [ACC_W-1:0]    result_q;
    logic                valid_q, done_q;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_el[k] = bus.weights[k*DATA_W +: DATA_W];
            i_el[k] = bus.inputs[k*DATA_W +: DATA_W];
        end
    end

    // Skewed edge injection: row i / column j start one step later per index
    always_comb begin
        a_row0 = '0;
        a_row1 = '0;
        b_col0 = '0;
        b_col1 = '0;
        if (bus.mmu_en) begin
            case (bus.mmu_cycle)
                3'd0: begin
                    a_row0 = w_el[0];
                    b_col0 = i_el[0];
                end
                3'd1: begin
                    a_row0 = w_el[1];
                    a_row1 = w_el[2];
                    b_col0 = i_el[2];
                    b_col1 = i_el[1];
                end
                3'd2: begin
                    a_row1 = w_el[3];
                    b_col1 = i_el[3];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pe_a[0] = a_row0;
        pe_b[0] = b_col0;
        pe_a[1] = a_fwd00;
        pe_b[1] = b_col1;
        pe_a[2] = a_row1;
        pe_b[2] = b_fwd00;
        pe_a[3] = a_fwd10;
        pe_b[3] = b_fwd01;
        for (int k = 0; k < 4; k++) begin
            prod[k] = pe_a[k] * pe_b[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !bus.mmu_en) begin
            a_fwd00 <= '0;
            a_fwd10 <= '0;
            b_fwd00 <= '0;
            b_fwd01 <= '0;
        end else begin
            a_fwd00 <= pe_a[0];
            a_fwd10 <= pe_a[2];
            b_fwd00 <= pe_b[0];
            b_fwd01 <= pe_b[1];
        end
    end

    // Step 0 overwrites so no residue survives from a prior operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else if (bus.mmu_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.mmu_cycle == 3'd0)
                    acc[k] <= ACC_W'(prod[k]);
                else if (bus.mmu_cycle <= 3'd3)
                    acc[k] <= acc[k] + ACC_W'(prod[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mmu_en && bus.mmu_cycle == 3'd0) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!bus.mmu_en) begin
                    state_d = IDLE;
                end else if (bus.mmu_cycle == 3'd4) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (bus.mmu_en && bus.mmu_cycle == 3'd0) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) holding[k] <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= capture;
            if (capture) begin
                for (int k = 0; k < 4; k++) holding[k] <= acc[k];
                valid_q <= 1'b1;
            end else if (start) begin
                valid_q <= 1'b0;
            end
            result_q <= holding[bus.output_select];
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_mmu_systolic_array.sv
// tb/tb_mmu_systolic_array.sv - self-checking bench for mmu_systolic_array against a matrix-product model
module tb_mmu_systolic_array;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    mmu_systolic_array_if #(.DATA_W(8), .ACC_W(16)) bus ();

    mmu_systolic_array #(.DATA_W(8), .ACC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_c(input int a[4], input int b[4], input int i, input int j);
        int s;
        s = a[i*2] * b[j] + a[i*2+1] * b[2+j];
        return 16'(s);
    endfunction

    function automatic logic [31:0] pack(input int m[4]);
        return {8'(m[3]), 8'(m[2]), 8'(m[1]), 8'(m[0])};
    endfunction

    task automatic step(input logic en, input int t);
        bus.mmu_en    = en;
        bus.mmu_cycle = 3'(t);
        @(posedge clk);
        #1;
    endtask

    task automatic read_sel(input int sel, output logic [15:0] val);
        bus.output_select = 2'(sel);
        @(posedge clk);
        #1;
        val = bus.result;
    endtask

    // Full control-unit sequence t=0,0,1,2,3,4,5; reports done pulses and state after the first step
    task automatic run_op(input int a[4], input int b[4], output int done_cnt, output int done_step,
                          output logic v0, output logic [15:0] r0);
        int seq[7] = '{0, 0, 1, 2, 3, 4, 5};
        bus.weights = pack(a);
        bus.inputs  = pack(b);
        done_cnt  = 0;
        done_step = -1;
        v0 = 1'bx;
        r0 = 'x;
        for (int s = 0; s < 7; s++) begin
            step(1'b1, seq[s]);
            if (s == 0) begin
                v0 = bus.result_valid;
                r0 = bus.result;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_step < 0) done_step = s;
            end
        end
        step(1'b0, 0);
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(1'b0, 0);
        step(1'b0, 0);
        tests_run++;
        if (bus.result !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_result got %0d want 0", bus.result);
        end
        tests_run++;
        if (bus.result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 0", bus.result_valid);
        end
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        rst_n = 1'b1;
        step(1'b0, 0);
    endtask

    task automatic test_abort();
        int a[4] = '{11, 22, 33, 44};
        int b[4] = '{55, 66, 77, 88};
        int dcnt;
        logic [15:0] v;
        bus.weights = pack(a);
        bus.inputs  = pack(b);
        dcnt = 0;
        step(1'b1, 0);
        if (bus.done === 1'b1) dcnt++;
        step(1'b1, 0);
        if (bus.done === 1'b1) dcnt++;
        step(1'b1, 1);
        if (bus.done === 1'b1) dcnt++;
        for (int s = 0; s < 4; s++) begin
            step(1'b0, 2 + s);
            if (bus.done === 1'b1) dcnt++;
        end
        tests_run++;
        if (dcnt !== 0) begin
            tests_failed++;
            $display("FAIL abort_done got %0d pulses want 0", dcnt);
        end
        tests_run++;
        if (bus.result_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_valid got %b want 0", bus.result_valid);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== 16'd0) begin
                tests_failed++;
                $display("FAIL abort_result sel %0d got %0d want 0", s, v);
            end
        end
    endtask

    task automatic test_basic();
        int a[4] = '{1, 2, 3, 4};
        int b[4] = '{5, 6, 7, 8};
        logic [15:0] exp[4] = '{16'd19, 16'd22, 16'd43, 16'd50};
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v;
        run_op(a, b, dcnt, dstep, v0, r0);
        tests_run++;
        if (dcnt !== 1 || dstep !== 5) begin
            tests_failed++;
            $display("FAIL basic_done got count %0d step %0d want count 1 step 5", dcnt, dstep);
        end
        tests_run++;
        if (bus.result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_valid got %b want 1", bus.result_valid);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== exp[s]) begin
                tests_failed++;
                $display("FAIL basic_result sel %0d got %0d want %0d", s, v, exp[s]);
            end
        end
    endtask

    task automatic test_max();
        int a[4] = '{255, 255, 255, 255};
        int b[4] = '{255, 255, 255, 255};
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v;
        run_op(a, b, dcnt, dstep, v0, r0);
        tests_run++;
        if (dcnt !== 1) begin
            tests_failed++;
            $display("FAIL max_done got %0d pulses want 1", dcnt);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== 16'd64514) begin
                tests_failed++;
                $display("FAIL max_result sel %0d got %0d want 64514", s, v);
            end
        end
    endtask

    task automatic test_second_op();
        int a[4] = '{1, 0, 0, 1};
        int b[4] = '{9, 8, 7, 6};
        logic [15:0] exp[4] = '{16'd9, 16'd8, 16'd7, 16'd6};
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v;
        bus.output_select = 2'd0;
        step(1'b0, 0);
        run_op(a, b, dcnt, dstep, v0, r0);
        tests_run++;
        if (v0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_valid_drop got %b want 0", v0);
        end
        tests_run++;
        if (r0 !== 16'd64514) begin
            tests_failed++;
            $display("FAIL second_old_hold got %0d want 64514", r0);
        end
        tests_run++;
        if (dcnt !== 1 || bus.result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL second_capture got done %0d valid %b want 1 1", dcnt, bus.result_valid);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== exp[s]) begin
                tests_failed++;
                $display("FAIL second_result sel %0d got %0d want %0d", s, v, exp[s]);
            end
        end
    endtask

    task automatic test_random();
        int a[4], b[4];
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 4; k++) begin
                a[k] = int'($urandom_range(0, 255));
                b[k] = int'($urandom_range(0, 255));
            end
            run_op(a, b, dcnt, dstep, v0, r0);
            tests_run++;
            if (dcnt !== 1 || dstep !== 5) begin
                tests_failed++;
                $display("FAIL rand_done op %0d got count %0d step %0d want 1 5", n, dcnt, dstep);
            end
            for (int s = 0; s < 4; s++) begin
                read_sel(s, v);
                tests_run++;
                if (v !== ref_c(a, b, s / 2, s % 2)) begin
                    tests_failed++;
                    $display("FAIL rand_result op %0d sel %0d got %0d want %0d", n, s, v, ref_c(a, b, s / 2, s % 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int a[4], b[4];
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v;
        for (int k = 0; k < 4; k++) begin
            a[k] = int'($urandom_range(0, 255));
            b[k] = int'($urandom_range(0, 255));
        end
        bus.weights = pack(a);
        bus.inputs  = pack(b);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 1);
        step(1'b1, 2);
        rst_n = 1'b0;
        step(1'b1, 3);
        tests_run++;
        if (bus.result !== 16'd0 || bus.result_valid !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got result %0d valid %b done %b want 0 0 0",
                     bus.result, bus.result_valid, bus.done);
        end
        rst_n = 1'b1;
        step(1'b0, 0);
        read_sel(3, v);
        tests_run++;
        if (v !== 16'd0) begin
            tests_failed++;
            $display("FAIL midreset_hold got %0d want 0", v);
        end
        run_op(a, b, dcnt, dstep, v0, r0);
        tests_run++;
        if (dcnt !== 1 || bus.result_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_rerun got done %0d valid %b want 1 1", dcnt, bus.result_valid);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(s, v);
            tests_run++;
            if (v !== ref_c(a, b, s / 2, s % 2)) begin
                tests_failed++;
                $display("FAIL midreset_result sel %0d got %0d want %0d", s, v, ref_c(a, b, s / 2, s % 2));
            end
        end
    endtask

    task automatic test_select_sweep();
        int a[4] = '{3, 5, 7, 9};
        int b[4] = '{2, 4, 6, 8};
        int order[4] = '{3, 2, 1, 0};
        int dcnt, dstep;
        logic v0;
        logic [15:0] r0, v, prev;
        run_op(a, b, dcnt, dstep, v0, r0);
        read_sel(0, prev);
        for (int n = 0; n < 4; n++) begin
            bus.output_select = 2'(order[n]);
            #1;
            tests_run++;
            if (bus.result !== prev) begin
                tests_failed++;
                $display("FAIL sweep_latency sel %0d got %0d want %0d", order[n], bus.result, prev);
            end
            read_sel(order[n], v);
            tests_run++;
            if (v !== ref_c(a, b, order[n] / 2, order[n] % 2)) begin
                tests_failed++;
                $display("FAIL sweep_value sel %0d got %0d want %0d", order[n], v, ref_c(a, b, order[n] / 2, order[n] % 2));
            end
            step(1'b0, 0);
            tests_run++;
            if (bus.result !== v) begin
                tests_failed++;
                $display("FAIL sweep_stable sel %0d got %0d want %0d", order[n], bus.result, v);
            end
            prev = v;
        end
    endtask

    initial begin
        tests_run         = 0;
        tests_failed      = 0;
        rst_n             = 1'b0;
        bus.mmu_en        = 1'b0;
        bus.mmu_cycle     = 3'd0;
        bus.weights       = '0;
        bus.inputs        = '0;
        bus.output_select = 2'd0;
        test_reset();
        test_abort();
        test_basic();
        test_max();
        test_second_op();
        test_random();
        test_reset_mid();
        test_select_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
